taxi_fare_meter: RTL

//  Parametrised taxi fare meter: ride-state FSM, distance- and waiting-time charging,
//  BCD fare accumulator and DIGITS-wide seven-segment drive.

---
 rtl/taxi_fare_meter_if.sv | 28 ++
 rtl/taxi_fare_meter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_fare_meter_if.sv
// rtl/taxi_fare_meter_if.sv - ride controls and fare/display outputs of the taxi fare meter
interface taxi_fare_meter_if #(
    parameter int DIGITS = 4
);
    logic                  ride;
    logic                  wait_sw;
    logic                  clear;
    logic                  dist_pulse;
`ifdef NIGHT_SURCHARGE_EN
    logic                  night;
`endif
    logic [4*DIGITS-1:0]   fare_bcd;
    logic [7*DIGITS-1:0]   hex;
    logic [1:0]            state;
    logic                  overflow;

`ifdef NIGHT_SURCHARGE_EN
    modport master (output ride, wait_sw, clear, dist_pulse, night,
                    input  fare_bcd, hex, state, overflow);
    modport slave  (input  ride, wait_sw, clear, dist_pulse, night,
                    output fare_bcd, hex, state, overflow);
`else
    modport master (output ride, wait_sw, clear, dist_pulse,
                    input  fare_bcd, hex, state, overflow);
    modport slave  (input  ride, wait_sw, clear, dist_pulse,
                    output fare_bcd, hex, state, overflow);
`endif
endinterface

// File: rtl/taxi_fare_meter.sv
// rtl/taxi_fare_meter.sv - taxi fare meter: ride FSM, distance/wait charging, BCD fare, 7-seg drive
// Optional NIGHT_SURCHARGE_EN adds a night input that raises per-km and wait charges by half.
module taxi_fare_meter #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 10,
    parameter int DIGITS        = 4,
    parameter int PULSES_PER_KM = 10,
    parameter int BASE_FARE     = 100,
    parameter int BASE_DIST     = 3,
    parameter int RATE_KM       = 20,
    parameter int WAIT_TICKS    = 600,
    parameter int WAIT_RATE     = 10
) (
    input  logic              clk_50m,
    input  logic              rst,
    taxi_fare_meter_if.slave  bus
);
    localparam int FW  = 4 * DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_STOP = 2'b11
    } state_t;

    function automatic logic [FW-1:0] to_bcd(input int unsigned v);
        logic [FW-1:0] r;
        int unsigned   t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    localparam logic [FW-1:0] BCD_BASE  = to_bcd(BASE_FARE);
    localparam logic [FW-1:0] BCD_KM    = to_bcd(RATE_KM);
    localparam logic [FW-1:0] BCD_WAIT  = to_bcd(WAIT_RATE);
    localparam logic [FW-1:0] BCD_NINES = {DIGITS{4'h9}};

`ifdef NIGHT_SURCHARGE_EN
    localparam int NSYNC = 5;
    localparam logic [FW-1:0] BCD_KM_N   = to_bcd(RATE_KM + RATE_KM / 2);
    localparam logic [FW-1:0] BCD_WAIT_N = to_bcd(WAIT_RATE + WAIT_RATE / 2);
    wire [NSYNC-1:0] w_async = {bus.night, bus.ride, bus.wait_sw, bus.clear, bus.dist_pulse};
`else
    localparam int NSYNC = 4;
    wire [NSYNC-1:0] w_async = {bus.ride, bus.wait_sw, bus.clear, bus.dist_pulse};
`endif

    logic [NSYNC-1:0] r_sync1;
    logic [NSYNC-1:0] r_sync2;
    logic             r_dist_d;
    logic [31:0]      r_div;
    state_t           r_state;
    logic [FW-1:0]    r_fare;
    logic [7:0]       r_km;
    logic [15:0]      r_pulse;
    logic [15:0]      r_wait;
    logic             r_ovf;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_dist_d <= 1'b0;
        end else begin
            r_sync1  <= w_async;
            r_sync2  <= r_sync1;
            r_dist_d <= r_sync2[0];
        end
    end

    wire w_ride      = r_sync2[3];
    wire w_wait_sw   = r_sync2[2];
    wire w_clear     = r_sync2[1];
    wire w_dist_edge = r_sync2[0] & ~r_dist_d;

    // Divider free-runs from reset so wait ticks are independent of ride boundaries.
    wire w_tick = (r_div == 32'(DIV - 1));

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)         r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 32'd1;
    end

    wire [7:0] w_km_next  = (r_km == 8'hFF) ? 8'hFF : r_km + 8'd1;
    wire       w_km_done  = w_dist_edge && (r_pulse == 16'(PULSES_PER_KM - 1));
    wire       w_wait_due = w_tick && (r_wait == 16'(WAIT_TICKS - 1));

    logic [FW-1:0] w_rate_km;
    logic [FW-1:0] w_rate_wait;
`ifdef NIGHT_SURCHARGE_EN
    assign w_rate_km   = r_sync2[4] ? BCD_KM_N   : BCD_KM;
    assign w_rate_wait = r_sync2[4] ? BCD_WAIT_N : BCD_WAIT;
`else
    assign w_rate_km   = BCD_KM;
    assign w_rate_wait = BCD_WAIT;
`endif

    logic          w_add_en;
    logic [FW-1:0] w_add_val;

    always_comb begin
        w_add_en  = 1'b0;
        w_add_val = '0;
        if (r_state == S_RUN && w_km_done && int'(w_km_next) > BASE_DIST) begin
            w_add_en  = 1'b1;
            w_add_val = w_rate_km;
        end else if (r_state == S_WAIT && w_wait_due) begin
            w_add_en  = 1'b1;
            w_add_val = w_rate_wait;
        end
    end

    logic [FW-1:0] w_sum;
    logic          w_carry;

    always_comb begin : bcd_add
        logic [4:0] s;
        logic       c;
        w_sum = '0;
        c     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, r_fare[4*i +: 4]} + {1'b0, w_add_val[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            w_sum[4*i +: 4] = s[3:0];
        end
        w_carry = c;
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fare  <= '0;
            r_km    <= '0;
            r_pulse <= '0;
            r_wait  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ride) begin
                        r_state <= S_RUN;
                        r_fare  <= BCD_BASE;
                        r_km    <= '0;
                        r_pulse <= '0;
                        r_wait  <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_km_done) begin
                        r_pulse <= '0;
                        r_km    <= w_km_next;
                    end else if (w_dist_edge) begin
                        r_pulse <= r_pulse + 16'd1;
                    end
                    if (!w_ride)        r_state <= S_STOP;
                    else if (w_wait_sw) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_wait_due)  r_wait <= '0;
                    else if (w_tick) r_wait <= r_wait + 16'd1;
                    if (!w_ride)         r_state <= S_STOP;
                    else if (!w_wait_sw) r_state <= S_RUN;
                end
                S_STOP: begin
                    if (w_clear) begin
                        r_state <= S_IDLE;
                        r_fare  <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Once saturated the fare is frozen until the meter is cleared.
            if (w_add_en && !r_ovf) begin
                if (w_carry) begin
                    r_fare <= BCD_NINES;
                    r_ovf  <= 1'b1;
                end else begin
                    r_fare <= w_sum;
                end
            end
        end
    end

    assign bus.fare_bcd = r_fare;
    assign bus.state    = r_state;
    assign bus.overflow = r_ovf;

    always_comb begin
        bus.hex = '0;
        for (int i = 0; i < DIGITS; i++)
            bus.hex[7*i +: 7] = seg7(r_fare[4*i +: 4]);
    end
endmodule
